// File: rtl/imm_decode_pkg.sv
// Shared opcode map, format codes and the immediate decode function used by
// the immediate-decode stage.
package imm_decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_NONE = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [63:0] imm;
        fmt_e        fmt;
        logic        illegal;
    } dec_t;

    // Immediate is built at 64 bits; callers keep the low XLEN bits, which
    // is still a correct sign extension for XLEN = 32.
    function automatic dec_t imm_decode(input logic [31:0] inst, input int xlen);
        dec_t r;
        r.imm     = '0;
        r.fmt     = FMT_NONE;
        r.illegal = 1'b0;
        case (inst[6:0])
            OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                r.fmt = FMT_I;
                r.imm = {{52{inst[31]}}, inst[31:20]};
            end
            OPC_OPIMM: begin
                // funct3 001 / 101 are the shifts: shamt only, inst[30] excluded
                if (inst[13:12] == 2'b01) begin
                    r.fmt = FMT_SH;
                    r.imm = (xlen == 64) ? {58'd0, inst[25:20]} : {59'd0, inst[24:20]};
                end else begin
                    r.fmt = FMT_I;
                    r.imm = {{52{inst[31]}}, inst[31:20]};
                end
            end
            OPC_STORE: begin
                r.fmt = FMT_S;
                r.imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                r.fmt = FMT_B;
                r.imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                r.fmt = FMT_U;
                r.imm = {{32{inst[31]}}, inst[31:12], 12'd0};
            end
            OPC_JAL: begin
                r.fmt = FMT_J;
                r.imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OPC_OP: begin
                r.fmt = FMT_R;
            end
            default: begin
                r.illegal = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_decode_stage_sync_fifo.sv
// Synchronous FIFO with flush; head entry is read combinationally so data is
// visible in the cycle right after it is written.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate-decode stage: decodes imm/format/target on the input side and
// buffers the results in a small FIFO between fetch and execute.
module imm_decode_stage
    import imm_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] target,
    output logic            illegal,
    output logic [15:0]     ill_count
);
    localparam int EW = XLEN + XLEN + 3 + 1;

    dec_t            dec;
    logic [XLEN-1:0] dec_imm, dec_target;
    logic [EW-1:0]   fifo_din, fifo_dout;
    logic            fifo_full, fifo_empty;
    logic            push, pop;
    logic [15:0]     ill_count_q, ill_count_d;

    assign dec        = imm_decode(inst, XLEN);
    assign dec_imm    = dec.imm[XLEN-1:0];
    assign dec_target = pc + dec_imm;
    assign fifo_din   = {dec_imm, dec_target, dec.fmt, dec.illegal};

    generate
        if (XLEN < 64) begin : g_unused_imm
            logic unused_imm_hi;
            assign unused_imm_hi = ^dec.imm[63:XLEN];
        end
    endgenerate

    // Ready depends only on the registered count, never on out_ready.
    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .full  (fifo_full),
        .empty (fifo_empty),
        .din   (fifo_din),
        .dout  (fifo_dout)
    );

    assign {imm, target, fmt, illegal} = fifo_dout;

    always_comb begin
        ill_count_d = ill_count_q;
        if (pop && illegal && (ill_count_q != 16'hFFFF)) begin
            ill_count_d = ill_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ill_count_q <= '0;
        else     ill_count_q <= ill_count_d;
    end

    assign ill_count = ill_count_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share stimulus and
// are checked every cycle against a queue-based model plus literal expectations.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] inst, pc32;
    logic [63:0] pc64;

    logic        r32_in_ready, r32_out_valid, r32_illegal;
    logic [31:0] r32_imm, r32_target;
    logic [2:0]  r32_fmt;
    logic [15:0] r32_ill;
    logic        r64_in_ready, r64_out_valid, r64_illegal;
    logic [63:0] r64_imm, r64_target;
    logic [2:0]  r64_fmt;
    logic [15:0] r64_ill;

    int n_tests = 0;
    int n_fail  = 0;

    assign pc64 = {32'h0, pc32};
    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .DEPTH(2)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32_in_ready),
        .inst(inst), .pc(pc32), .out_valid(r32_out_valid), .out_ready(out_ready),
        .imm(r32_imm), .fmt(r32_fmt), .target(r32_target), .illegal(r32_illegal),
        .ill_count(r32_ill)
    );

    imm_decode_stage #(.XLEN(64), .DEPTH(2)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64_in_ready),
        .inst(inst), .pc(pc64), .out_valid(r64_out_valid), .out_ready(out_ready),
        .imm(r64_imm), .fmt(r64_fmt), .target(r64_target), .illegal(r64_illegal),
        .ill_count(r64_ill)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode written directly from the opcode table using signed values.
    function automatic void ref_decode(input logic [31:0] i, input int xlen,
                                       output longint im, output int f, output bit il);
        logic signed [11:0] v12;
        logic signed [12:0] v13;
        logic signed [20:0] v21;
        logic signed [31:0] v32;
        logic [2:0]         f3;
        f3 = i[14:12];
        im = 0; f = 7; il = 0;
        case (i[6:0])
            7'h03, 7'h67, 7'h73: begin v12 = i[31:20]; im = v12; f = 1; end
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    f = 6;
                    im = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
                end else begin
                    v12 = i[31:20]; im = v12; f = 1;
                end
            end
            7'h23: begin v12 = {i[31:25], i[11:7]}; im = v12; f = 2; end
            7'h63: begin v13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; im = v13; f = 3; end
            7'h37, 7'h17: begin v32 = {i[31:12], 12'h000}; im = v32; f = 4; end
            7'h6F: begin v21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; im = v21; f = 5; end
            7'h33: f = 0;
            default: il = 1;
        endcase
    endfunction

    typedef struct {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [31:0] tgt32;
        logic [63:0] tgt64;
        logic [2:0]  fmt;
        bit          ill;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_ill = 16'd0;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        int     sz;
        bit     do_push;
        ent_t   e, h;
        longint i32, i64;
        int     f;
        bit     il;
        sz = q.size();
        if (rst) begin
            q.delete();
            m_ill = 16'd0;
            model_ok = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            do_push = in_valid && (sz != 2);
            if (do_push) begin
                ref_decode(inst, 32, i32, f, il);
                ref_decode(inst, 64, i64, f, il);
                e.imm32 = i32[31:0];
                e.imm64 = i64;
                e.tgt32 = pc32 + i32[31:0];
                e.tgt64 = pc64 + i64;
                e.fmt   = f[2:0];
                e.ill   = il;
            end
            if (out_ready && sz != 0) begin
                h = q.pop_front();
                if (h.ill && m_ill != 16'hFFFF) m_ill = m_ill + 16'd1;
            end
            if (do_push) q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("in_ready32", r32_in_ready, q.size() != 2);
            chk("in_ready64", r64_in_ready, q.size() != 2);
            chk("out_valid32", r32_out_valid, q.size() != 0);
            chk("out_valid64", r64_out_valid, q.size() != 0);
            chk("ill_count32", r32_ill, m_ill);
            chk("ill_count64", r64_ill, m_ill);
            if (q.size() != 0) begin
                chk("imm32", r32_imm, q[0].imm32);
                chk("imm64", r64_imm, q[0].imm64);
                chk("target32", r32_target, q[0].tgt32);
                chk("target64", r64_target, q[0].tgt64);
                chk("fmt32", r32_fmt, q[0].fmt);
                chk("fmt64", r64_fmt, q[0].fmt);
                chk("illegal32", r32_illegal, q[0].ill);
                chk("illegal64", r64_illegal, q[0].ill);
            end
        end
    end

    task automatic step(input bit v, input logic [31:0] i, input logic [31:0] p,
                        input bit ordy, input bit fl, input bit rs);
        in_valid = v; inst = i; pc32 = p; out_ready = ordy; flush = fl; rst = rs;
        @(posedge clk);
        #2;
    endtask

    initial begin
        longint mi;
        int     mf;
        bit     ml;

        // Pin the reference decoder itself.
        ref_decode(32'hFE000EE3, 32, mi, mf, ml);
        chk("model_beq_imm", mi, 64'hFFFFFFFFFFFFFFFC);
        ref_decode(32'h43F05093, 64, mi, mf, ml);
        chk("model_srai_imm", mi, 64'd63);
        chk("model_srai_fmt", mf, 64'd6);

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        $display("[TB] reset applied");
        chk("rst_in_ready", r32_in_ready, 1);
        chk("rst_out_valid", r32_out_valid, 0);
        chk("rst_ill_count", r32_ill, 0);

        step(1, 32'hFFF00093, 32'h100, 1, 0, 0);
        $display("[TB] addi -1 pc=0x100");
        chk("addi_valid", r32_out_valid, 1);
        chk("addi_imm32", r32_imm, 32'hFFFFFFFF);
        chk("addi_fmt", r32_fmt, 1);
        chk("addi_tgt32", r32_target, 32'hFF);
        chk("addi_imm64", r64_imm, 64'hFFFFFFFFFFFFFFFF);
        chk("addi_tgt64", r64_target, 64'hFF);

        step(1, 32'hFE000EE3, 32'h200, 1, 0, 0);
        $display("[TB] beq -4 pc=0x200");
        chk("beq_imm32", r32_imm, 32'hFFFFFFFC);
        chk("beq_fmt", r32_fmt, 3);
        chk("beq_tgt32", r32_target, 32'h1FC);

        step(1, 32'h0080006F, 32'h300, 1, 0, 0);
        $display("[TB] jal +8 pc=0x300");
        chk("jal_imm32", r32_imm, 32'h8);
        chk("jal_fmt", r32_fmt, 5);
        chk("jal_tgt32", r32_target, 32'h308);

        step(1, 32'h800002B7, 32'h1000, 1, 0, 0);
        $display("[TB] lui 0x80000");
        chk("lui_imm64", r64_imm, 64'hFFFFFFFF80000000);
        chk("lui_fmt64", r64_fmt, 4);
        chk("lui_imm32", r32_imm, 32'h80000000);

        step(1, 32'h43F05093, 32'h0, 1, 0, 0);
        $display("[TB] srai shamt 63");
        chk("srai_imm64", r64_imm, 64'd63);
        chk("srai_fmt64", r64_fmt, 6);
        chk("srai_imm32", r32_imm, 32'd31);

        step(1, 32'h00112623, 32'h40, 1, 0, 0);
        $display("[TB] sw offset 12");
        chk("sw_imm32", r32_imm, 32'd12);
        chk("sw_fmt", r32_fmt, 2);

        step(1, 32'h002081B3, 32'h0, 1, 0, 0);
        $display("[TB] add (R-type)");
        chk("add_fmt", r32_fmt, 0);

        step(1, 32'hFFF00093, 32'h0, 1, 0, 0);
        $display("[TB] addi -1 pc=0 (target wraps)");
        chk("wrap_tgt32", r32_target, 32'hFFFFFFFF);
        chk("wrap_tgt64", r64_target, 64'hFFFFFFFFFFFFFFFF);

        step(0, 0, 0, 1, 0, 0);
        $display("[TB] drain");
        chk("drain_valid", r32_out_valid, 0);

        // Backpressure: third instruction must wait upstream.
        step(1, 32'h00100093, 32'h0, 0, 0, 0);
        $display("[TB] bp push A");
        step(1, 32'h00200093, 32'h4, 0, 0, 0);
        $display("[TB] bp push B");
        chk("bp_full_ready", r32_in_ready, 0);
        chk("bp_head_A", r32_imm, 32'd1);
        for (int k = 0; k < 2; k++) begin
            step(1, 32'h00300093, 32'h8, 0, 0, 0);
            $display("[TB] bp hold C cycle %0d", k);
            chk("bp_hold_ready", r32_in_ready, 0);
            chk("bp_hold_head", r32_imm, 32'd1);
        end
        step(1, 32'h00300093, 32'h8, 1, 0, 0);
        $display("[TB] bp pop A, C refused");
        chk("bp_head_B", r32_imm, 32'd2);
        chk("bp_ready_again", r32_in_ready, 1);
        step(1, 32'h00300093, 32'h8, 1, 0, 0);
        $display("[TB] bp push C, pop B");
        chk("bp_head_C", r32_imm, 32'd3);
        step(0, 0, 0, 1, 0, 0);
        $display("[TB] bp drain C");
        chk("bp_empty", r32_out_valid, 0);

        // Illegal opcode accounting.
        step(1, 32'h0000007F, 32'h0, 0, 0, 0);
        $display("[TB] push illegal 1");
        chk("ill_flag", r32_illegal, 1);
        chk("ill_fmt", r32_fmt, 7);
        chk("ill_imm", r32_imm, 0);
        step(1, 32'h0000007F, 32'h0, 0, 0, 0);
        $display("[TB] push illegal 2");
        step(0, 0, 0, 1, 0, 0);
        $display("[TB] pop illegal 1");
        step(0, 0, 0, 1, 0, 0);
        $display("[TB] pop illegal 2");
        chk("ill_count2_32", r32_ill, 2);
        chk("ill_count2_64", r64_ill, 2);

        // Flush with one entry buffered, then flush racing a push.
        step(1, 32'h00100093, 32'h0, 0, 0, 0);
        $display("[TB] push before flush");
        step(0, 0, 0, 0, 1, 0);
        $display("[TB] flush");
        chk("flush_valid", r32_out_valid, 0);
        chk("flush_ill_kept", r32_ill, 2);
        step(1, 32'h00500093, 32'h0, 1, 1, 0);
        $display("[TB] flush with push");
        chk("flush_push_dropped", r32_out_valid, 0);

        // Reset mid-stream with in_valid high.
        step(1, 32'h00100093, 32'h0, 0, 0, 0);
        $display("[TB] push before rst 1");
        step(1, 32'h00200093, 32'h0, 0, 0, 0);
        $display("[TB] push before rst 2");
        step(1, 32'h00300093, 32'h0, 0, 0, 1);
        $display("[TB] rst mid-stream");
        chk("rst2_valid", r32_out_valid, 0);
        chk("rst2_ready", r32_in_ready, 1);
        chk("rst2_ill", r32_ill, 0);
        step(0, 0, 0, 0, 0, 0);
        $display("[TB] idle after rst");
        chk("rst2_nothing_taken", r32_out_valid, 0);

        step(0, 0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

- Registered, parametrised immediate-decode stage for the processor front end.
- Accepts raw instructions with their PC over a valid/ready handshake and decodes the immediate for every RV32I/RV64I format (I, S, B, U, J, shift-immediate). Each immediate is sign-extended to XLEN.
- Computes the PC-relative target and flags unknown opcodes.
- Results are buffered in a DEPTH-entry FIFO so the stage sits between fetch and execute at full throughput, with no combinational ready path.

## Interface
- XLEN, 32, datapath width; 32 or 64.
- DEPTH, 2, FIFO entries; power of two, ≥ 2.
- clk  input  1  clock; one clock domain.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  instruction offered.
- in_ready  output  1  stage can accept this cycle.
- inst  input  32  instruction word.
- pc  input  XLEN  instruction address.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes head entry.
- imm  output  XLEN  decoded immediate.
- fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, SH=6, NONE=7.
- target  output  XLEN  pc + imm, modulo 2^XLEN.
- illegal  output  1  opcode not recognised.
- ill_count  output  16  saturating count of illegal instructions dequeued.

## Operation
- Decode is combinational on the input side; the decoded entry is written to the FIFO.
  - An entry holds imm, fmt, target and illegal.
- Opcode map:
  - 0000011, 1100111, 1110011 → I: sign-extend inst[31:20].
  - 0010011 → I, except when funct3 is 001 or 101 → SH.
    - SH imm is zero-extended inst[20 +: log2(XLEN)].
    - inst[30] is not part of the immediate.
  - 0100011 → S: sign-extend {inst[31:25], inst[11:7]}.
  - 1100011 → B: sign-extend {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - 0110111, 0010111 → U: sign-extend {inst[31:12], 12'b0}.
  - 1101111 → J: sign-extend {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - 0110011 → R: imm = 0.
  - Any other opcode → NONE: imm = 0, illegal = 1.
- funct3 is ignored except for the SH distinction.
- All formats compute target; consumers ignore it where it is meaningless.
- Handshake:
  - Push when in_valid && in_ready && !flush.
  - Pop when out_valid && out_ready && !flush.
  - Push and pop in the same cycle are both performed; count is unchanged.
- in_ready = (count != DEPTH). It is derived from registered state only.
  - A full FIFO does not accept, even when a pop occurs that cycle.
- out_valid = (count != 0). Outputs are driven from the head entry.
  - Outputs hold stable while out_valid && !out_ready.
- ill_count increments on every pop with illegal = 1.
  - It saturates at 16'hFFFF.
  - It is cleared by rst only, not by flush.
- flush:
  - Resets the pointers and count to 0.
  - A push or pop presented in the same cycle is dropped.

## Timing
- Latency: an instruction accepted at edge N appears on outputs after edge N; out_valid is high from that cycle onward.
- Throughput: one instruction per cycle when the consumer keeps out_ready high.
- Reset values:
  - in_ready = 1, out_valid = 0, ill_count = 0.
  - Read pointer, write pointer and count = 0.
  - imm, fmt, target and illegal show the head entry. Head RAM contents are don't-care while out_valid = 0; the bench does not check them.
- rst mid-stream: all buffered entries are lost at the next edge; the behaviour is the same as flush, and ill_count is also cleared.
- rst has priority over flush; flush has priority over push and pop.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

## Structure
- A shared package imm_decode_pkg holds:
  - The opcode localparams.
  - The fmt enum/constants.
  - The decode function (inst, XLEN) → {imm, fmt, illegal}.
- One sub-module: sync_fifo.
  - Parameters: width and DEPTH.
  - Ports: push, pop, flush, rst, full, empty, din, dout.
  - The top instantiates it with width XLEN+XLEN+3+1.
- The target adder and ill_count live in the top.

## Test plan
- XLEN=32, out_ready=1, inst=0xFFF00093 (addi, imm −1), pc=0x100 → next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1, target=0xFF.
- inst=0xFE000EE3 (beq offset −4), pc=0x200 → imm=0xFFFFFFFC, fmt=3, target=0x1FC. inst=0x0080006F (jal +8) → imm=8, fmt=5.
- XLEN=64: inst=0x800002B7 (lui) → imm=0xFFFFFFFF80000000, fmt=4. inst=0x43F05093 (srai by 63) → imm=63, fmt=6.
- DEPTH=2, out_ready=0, push 3 instructions → in_ready drops after 2; the third is held upstream. Then assert out_ready → the entries drain in order.
- Push inst=0x0000007F twice and pop both → illegal=1, fmt=7, imm=0, ill_count=2. Assert flush with 1 entry buffered → out_valid=0 next cycle, ill_count unchanged.
- Assert rst with 2 entries buffered and in_valid high → after the edge: out_valid=0, in_ready=1, ill_count=0, and nothing was accepted that cycle.
